// File: rtl/sync_stream_fifo_if.sv
// Stream handshake bundle between a producer/consumer pair and the
// sync_stream_fifo. The master side drives the write word and the read
// acceptance. The slave side (the FIFO) drives the head word and the status flags.
interface sync_stream_fifo_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  fifo_write_tvalid;
    logic                  fifo_write_tready;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic                  fifo_read_tready;
    logic                  fifo_read_tvalid;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_almost_full;
    logic                  fifo_empty;
    logic                  fifo_full;

    modport master (
        output fifo_write_tvalid,
        output fifo_wdata,
        output fifo_read_tready,
        input  fifo_write_tready,
        input  fifo_read_tvalid,
        input  fifo_rdata,
        input  fifo_almost_full,
        input  fifo_empty,
        input  fifo_full
    );

    modport slave (
        input  fifo_write_tvalid,
        input  fifo_wdata,
        input  fifo_read_tready,
        output fifo_write_tready,
        output fifo_read_tvalid,
        output fifo_rdata,
        output fifo_almost_full,
        output fifo_empty,
        output fifo_full
    );
endinterface

// File: rtl/sync_stream_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// It buffers wide words (for example AES blocks) between the bus-side assembler
// and the AES core. The head word is always presented combinationally from
// storage, so a word written on one edge is visible immediately after it.
// Status flags are pure decodes of the registered occupancy count.
module sync_stream_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 16
) (
    input logic               clk,
    input logic               reset,
    sync_stream_fifo_if.slave fifo
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT        = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ALMOST_FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;

    logic is_empty;
    logic is_full;
    logic do_write;
    logic do_read;

    // The flags come only from the registered count. Write acceptance ignores
    // read_tready, so a full FIFO refuses a write even in a cycle that pops.
    always_comb begin
        is_empty = (count == '0);
        is_full  = (count == FULL_COUNT);
        do_write = fifo.fifo_write_tvalid && !is_full;
        do_read  = fifo.fifo_read_tready && !is_empty;
    end

    assign fifo.fifo_empty        = is_empty;
    assign fifo.fifo_full         = is_full;
    assign fifo.fifo_almost_full  = (count >= ALMOST_FULL_COUNT);
    assign fifo.fifo_write_tready = !is_full;
    assign fifo.fifo_read_tvalid  = !is_empty;
    assign fifo.fifo_rdata        = mem[rd_ptr];

    // Storage is not reset, so a reset leaves stale words that the cleared
    // pointers simply no longer expose.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= fifo.fifo_wdata;
        end
    end

    // Pointers wrap naturally at DEPTH. The count tracks the net change, so a
    // simultaneous push and pop leaves it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_stream_fifo.sv
// Directed bench for sync_stream_fifo: reset, fill/drain, fall-through
// latency, steady streaming, full-with-pop and pointer wrap-around.
module tb_sync_stream_fifo;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 128;
    localparam int DEPTH      = 16;

    logic clk;
    logic reset;

    int tests_run;
    int tests_failed;

    sync_stream_fifo_if #(.DATA_WIDTH(DATA_WIDTH)) fifo_bus ();

    sync_stream_fifo #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .fifo (fifo_bus.slave)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [DATA_WIDTH-1:0] observed,
                               input logic [DATA_WIDTH-1:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wvalid, input logic [DATA_WIDTH-1:0] wdata,
                                 input logic rready);
        fifo_bus.fifo_write_tvalid = wvalid;
        fifo_bus.fifo_wdata        = wdata;
        fifo_bus.fifo_read_tready  = rready;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence: every expected value below is computed by hand.
    initial begin
        logic wv;
        logic rr;
        int   next_in;
        int   next_out;
        int   cycles;

        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        waitCycle();
        waitCycle();

        checkOutput("rst_empty",  128'(fifo_bus.fifo_empty), 128'(1));
        checkOutput("rst_full",   128'(fifo_bus.fifo_full), 128'(0));
        checkOutput("rst_af",     128'(fifo_bus.fifo_almost_full), 128'(0));
        checkOutput("rst_tvalid", 128'(fifo_bus.fifo_read_tvalid), 128'(0));
        checkOutput("rst_tready", 128'(fifo_bus.fifo_write_tready), 128'(1));
        reset = 1'b1;
        waitCycle();

        // Asynchronous reset in the middle of a cycle while 5 words are stored.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 128'(32'h50 + i), 1'b0);
            waitCycle();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("pre_rst_tvalid", 128'(fifo_bus.fifo_read_tvalid), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_rst_empty",  128'(fifo_bus.fifo_empty), 128'(1));
        checkOutput("async_rst_tvalid", 128'(fifo_bus.fifo_read_tvalid), 128'(0));
        checkOutput("async_rst_tready", 128'(fifo_bus.fifo_write_tready), 128'(1));
        checkOutput("async_rst_full",   128'(fifo_bus.fifo_full), 128'(0));
        waitCycle();
        reset = 1'b1;
        waitCycle();
        applyStimulus(1'b1, 128'h1, 1'b0);
        waitCycle();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("post_rst_data", fifo_bus.fifo_rdata, 128'h1);
        waitCycle();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post_rst_empty", 128'(fifo_bus.fifo_empty), 128'(1));

        // Fill 0..15 with the consumer stalled, then a blocked 17th word.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 128'(i), 1'b0);
            waitCycle();
            if (i == DEPTH - 2) begin
                checkOutput("fill15_af",   128'(fifo_bus.fifo_almost_full), 128'(1));
                checkOutput("fill15_full", 128'(fifo_bus.fifo_full), 128'(0));
            end
        end
        checkOutput("fill16_full",   128'(fifo_bus.fifo_full), 128'(1));
        checkOutput("fill16_tready", 128'(fifo_bus.fifo_write_tready), 128'(0));
        checkOutput("fill16_af",     128'(fifo_bus.fifo_almost_full), 128'(1));
        applyStimulus(1'b1, 128'hDEAD, 1'b0);
        repeat (3) waitCycle();
        checkOutput("blocked_full", 128'(fifo_bus.fifo_full), 128'(1));
        checkOutput("blocked_head", fifo_bus.fifo_rdata, 128'h0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("drain_data",   fifo_bus.fifo_rdata, 128'(i));
            checkOutput("drain_tvalid", 128'(fifo_bus.fifo_read_tvalid), 128'(1));
            waitCycle();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("drain_empty", 128'(fifo_bus.fifo_empty), 128'(1));

        // Fall-through: a word written at edge N is the head right after N.
        applyStimulus(1'b1, 128'hA5, 1'b1);
        waitCycle();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("fwft_tvalid", 128'(fifo_bus.fifo_read_tvalid), 128'(1));
        checkOutput("fwft_data",   fifo_bus.fifo_rdata, 128'hA5);
        waitCycle();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("fwft_empty", 128'(fifo_bus.fifo_empty), 128'(1));

        // Steady streaming at occupancy 8 for 20 cycles.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 128'(100 + i), 1'b0);
            waitCycle();
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 128'(108 + i), 1'b1);
            checkOutput("rw8_data", fifo_bus.fifo_rdata, 128'(100 + i));
            waitCycle();
            checkOutput("rw8_flags", 128'({fifo_bus.fifo_empty, fifo_bus.fifo_full,
                                           fifo_bus.fifo_almost_full}), 128'(0));
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("rw8_tail", fifo_bus.fifo_rdata, 128'(120 + i));
            waitCycle();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("rw8_empty", 128'(fifo_bus.fifo_empty), 128'(1));

        // Full with push and pop in the same cycle: only the pop happens.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 128'(200 + i), 1'b0);
            waitCycle();
        end
        applyStimulus(1'b1, 128'hBEEF, 1'b1);
        checkOutput("fullrw_head", fifo_bus.fifo_rdata, 128'(200));
        waitCycle();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("fullrw_full",   128'(fifo_bus.fifo_full), 128'(0));
        checkOutput("fullrw_af",     128'(fifo_bus.fifo_almost_full), 128'(1));
        checkOutput("fullrw_tready", 128'(fifo_bus.fifo_write_tready), 128'(1));
        checkOutput("fullrw_next",   fifo_bus.fifo_rdata, 128'(201));
        for (int i = 0; i < DEPTH - 1; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("fullrw_drain", fifo_bus.fifo_rdata, 128'(201 + i));
            waitCycle();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("fullrw_empty", 128'(fifo_bus.fifo_empty), 128'(1));

        // Wrap-around: 40 words with random valid/ready, expected 0..39 in order.
        next_in  = 0;
        next_out = 0;
        cycles   = 0;
        while (next_out < 40 && cycles < 2000) begin
            wv = (next_in < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
            rr = 1'($urandom_range(0, 1));
            applyStimulus(wv, 128'(next_in), rr);
            if (rr && fifo_bus.fifo_read_tvalid) begin
                checkOutput("wrap_data", fifo_bus.fifo_rdata, 128'(next_out));
                next_out++;
            end
            if (wv && fifo_bus.fifo_write_tready) begin
                next_in++;
            end
            waitCycle();
            cycles++;
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("wrap_out_count", 128'(next_out), 128'(40));
        checkOutput("wrap_in_count",  128'(next_in), 128'(40));
        checkOutput("wrap_empty",     128'(fifo_bus.fifo_empty), 128'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
